// File: rtl/data_write_buffer.sv
// Write buffer between the core data port and the bridge data port: posted writes, in-order reads.
// Optional read forwarding from buffered word writes is enabled by defining WB_READ_FORWARD_EN.
module data_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OWC_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } wb_entry_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OWC_W-1:0] owc_q, owc_d;
  logic             wr_done_q, wr_done_d;
  wb_entry_t        buf_q [DEPTH];
  wb_entry_t        buf_d [DEPTH];

  wb_entry_t head;
  logic      full, empty, drained;
  logic      push, pop, rd_issue, owc_inc, owc_dec;

`ifdef WB_READ_FORWARD_EN
  logic        fwd_done_q, fwd_done_d;
  logic [31:0] fwd_data_q, fwd_data_d;
  logic        fwd_any, fwd_sub, fwd_hit;
  logic [31:0] fwd_word;

  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    fwd_any  = 1'b0;
    fwd_sub  = 1'b0;
    fwd_word = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) &&
          (buf_q[rd_ptr_q + PTR_W'(k)].addr[31:2] == cpu_addr[31:2])) begin
        fwd_any  = 1'b1;
        fwd_word = buf_q[rd_ptr_q + PTR_W'(k)].wdata;
        if (buf_q[rd_ptr_q + PTR_W'(k)].size != 2'b10) begin
          fwd_sub = 1'b1;
        end
      end
    end
    fwd_hit = fwd_any && !fwd_sub;
  end
`endif

  assign head    = buf_q[rd_ptr_q];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign drained = empty && (owc_q == '0);

  // Next-state, FIFO bookkeeping and handshake outputs.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    owc_d       = owc_q;
    buf_d       = buf_q;
    push        = 1'b0;
    pop         = 1'b0;
    rd_issue    = 1'b0;
    owc_inc     = 1'b0;
    owc_dec     = 1'b0;
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = '0;
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    mem_size    = head.size;
    mem_addr    = head.addr;
    mem_wdata   = head.wdata;
`ifdef WB_READ_FORWARD_EN
    fwd_done_d  = 1'b0;
    fwd_data_d  = fwd_data_q;
`endif

    if (state_q == IDLE) begin
      if (cpu_req && cpu_wr) begin
        if (!full) begin
          cpu_addr_ok = 1'b1;
          push        = 1'b1;
        end
      end else if (cpu_req) begin
`ifdef WB_READ_FORWARD_EN
        if (fwd_hit) begin
          cpu_addr_ok = 1'b1;
          fwd_done_d  = 1'b1;
          fwd_data_d  = fwd_word;
        end else
`endif
        if (drained) begin
          rd_issue    = 1'b1;
          mem_req     = 1'b1;
          mem_wr      = 1'b0;
          mem_size    = cpu_size;
          mem_addr    = cpu_addr;
          mem_wdata   = cpu_wdata;
          cpu_addr_ok = mem_addr_ok;
          if (mem_addr_ok) begin
            state_d = RD_WAIT;
          end
        end
      end

      // Drain the head unless too many writes are already in flight.
      if (!rd_issue && !empty && (owc_q != 3'd7)) begin
        mem_req = 1'b1;
        mem_wr  = 1'b1;
        pop     = mem_addr_ok;
      end
      owc_dec = mem_data_ok && (owc_q != '0);
    end else begin
      cpu_data_ok = mem_data_ok;
      cpu_rdata   = mem_data_ok ? mem_rdata : 32'h0;
      if (mem_data_ok) begin
        state_d = IDLE;
      end
    end

    if (wr_done_q) begin
      cpu_data_ok = 1'b1;
    end
`ifdef WB_READ_FORWARD_EN
    if (fwd_done_q) begin
      cpu_data_ok = 1'b1;
      cpu_rdata   = fwd_data_q;
    end
`endif

    if (push) begin
      buf_d[wr_ptr_q] = '{size: cpu_size, addr: cpu_addr, wdata: cpu_wdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    owc_inc   = pop;
    owc_d     = owc_q + OWC_W'(owc_inc) - OWC_W'(owc_dec);
    wr_done_d = push;

    // Hold the core and bridge quiet while reset is asserted.
    if (!resetn) begin
      cpu_addr_ok = 1'b0;
      cpu_data_ok = 1'b0;
      cpu_rdata   = '0;
      mem_req     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      owc_q      <= '0;
      wr_done_q  <= 1'b0;
`ifdef WB_READ_FORWARD_EN
      fwd_done_q <= 1'b0;
      fwd_data_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      owc_q      <= owc_d;
      wr_done_q  <= wr_done_d;
`ifdef WB_READ_FORWARD_EN
      fwd_done_q <= fwd_done_d;
      fwd_data_q <= fwd_data_d;
`endif
    end
  end

  // Entry storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed bench for data_write_buffer (DEPTH=4); forwarding cases follow WB_READ_FORWARD_EN.
module tb_data_write_buffer;

  logic        clk;
  logic        resetn;
  logic        cpu_req, cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_fail;

  data_write_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_size   (cpu_size),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok),
    .cpu_rdata  (cpu_rdata),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_size   (mem_size),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req   = req;
    cpu_wr    = wr;
    cpu_size  = size;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  // One write buffered with the bridge stalled and a read already driven:
  // the read must wait for drain, then go to memory and complete.
  task automatic drain_then_read(input string tag, input logic [31:0] raddr, input logic [31:0] rdat);
    #2 check_eq({tag, "_hold0"}, 32'(cpu_addr_ok), 32'd0);
    next_cyc();
    mem_addr_ok = 1'b1;
    #2 check_eq({tag, "_hold1"}, 32'(cpu_addr_ok), 32'd0);
    check_eq({tag, "_wrdrain"}, 32'(mem_wr), 32'd1);
    next_cyc();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    #2 check_eq({tag, "_hold2"}, 32'(cpu_addr_ok), 32'd0);
    next_cyc();
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b1;
    #2 check_eq({tag, "_rdacc"}, 32'(cpu_addr_ok), 32'd1);
    check_eq({tag, "_rdwr"}, 32'(mem_wr), 32'd0);
    check_eq({tag, "_rdaddr"}, mem_addr, raddr);
    next_cyc();
    cpu_req     = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = rdat;
    #2 check_eq({tag, "_rdok"}, 32'(cpu_data_ok), 32'd1);
    check_eq({tag, "_rdata"}, cpu_rdata, rdat);
    next_cyc();
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    resetn      = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    cpu_drive(1'b1, 1'b1, 2'b10, 32'h10, 32'h1);

    // Reset: outputs held quiet even with a request present
    next_cyc();
    #2 check_eq("rst_addr_ok", 32'(cpu_addr_ok), 32'd0);
    check_eq("rst_data_ok", 32'(cpu_data_ok), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_rdata", cpu_rdata, 32'd0);
    next_cyc();
    cpu_req = 1'b0;
    resetn  = 1'b1;

    // Fill the buffer with the bridge stalled
    for (int i = 0; i < 4; i++) begin
      cpu_drive(1'b1, 1'b1, 2'b10, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
      #2 check_eq("fill_acc", 32'(cpu_addr_ok), 32'd1);
      check_eq("fill_ok", 32'(cpu_data_ok), 32'(i > 0));
      if (i == 0) check_eq("fill_mreq0", 32'(mem_req), 32'd0);
      if (i == 1) begin
        check_eq("fill_mwr", 32'(mem_wr), 32'd1);
        check_eq("fill_maddr", mem_addr, 32'h10);
        check_eq("fill_mwdata", mem_wdata, 32'hA0);
      end
      next_cyc();
    end
    cpu_drive(1'b1, 1'b1, 2'b10, 32'h20, 32'hA4);
    #2 check_eq("full_acc", 32'(cpu_addr_ok), 32'd0);
    check_eq("full_ok_last", 32'(cpu_data_ok), 32'd1);
    next_cyc();
    #2 check_eq("full_acc2", 32'(cpu_addr_ok), 32'd0);
    check_eq("full_ok2", 32'(cpu_data_ok), 32'd0);
    mem_addr_ok = 1'b1;
    #1 check_eq("full_nocredit", 32'(cpu_addr_ok), 32'd0);
    check_eq("full_head", mem_addr, 32'h10);
    next_cyc();
    mem_addr_ok = 1'b0;
    #2 check_eq("full_acc_after_pop", 32'(cpu_addr_ok), 32'd1);
    check_eq("full_head2", mem_addr, 32'h14);
    next_cyc();
    cpu_req = 1'b0;
    #2 check_eq("fifth_ok", 32'(cpu_data_ok), 32'd1);
    next_cyc();
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 check_eq("drain_req", 32'(mem_req), 32'd1);
      check_eq("drain_addr", mem_addr, 32'h14 + 32'(4 * i));
      next_cyc();
    end
    mem_addr_ok = 1'b0;
    #2 check_eq("drain_empty", 32'(mem_req), 32'd0);
    mem_data_ok = 1'b1;
    #1 check_eq("wr_mdok_no_cpu_ok", 32'(cpu_data_ok), 32'd0);
    for (int i = 0; i < 5; i++) next_cyc();
    mem_data_ok = 1'b0;

    // Write then read: read goes out only after the write's completion
    cpu_drive(1'b1, 1'b1, 2'b10, 32'h100, 32'h1234_5678);
    #2 check_eq("wr_read_wacc", 32'(cpu_addr_ok), 32'd1);
    next_cyc();
    cpu_drive(1'b1, 1'b0, 2'b10, 32'h200, 32'h0);
    mem_addr_ok = 1'b1;
    #2 check_eq("wrrd_mwr", 32'(mem_wr), 32'd1);
    check_eq("wrrd_maddr", mem_addr, 32'h100);
    check_eq("wrrd_mwdata", mem_wdata, 32'h1234_5678);
    check_eq("wrrd_rd_hold", 32'(cpu_addr_ok), 32'd0);
    check_eq("wrrd_wok", 32'(cpu_data_ok), 32'd1);
    next_cyc();
    #2 check_eq("wrrd_wait1", 32'(mem_req), 32'd0);
    next_cyc();
    #2 check_eq("wrrd_wait2", 32'(mem_req), 32'd0);
    next_cyc();
    mem_data_ok = 1'b1;
    #2 check_eq("wrrd_wait3", 32'(mem_req), 32'd0);
    check_eq("wrrd_hold3", 32'(cpu_addr_ok), 32'd0);
    check_eq("wrrd_nook", 32'(cpu_data_ok), 32'd0);
    next_cyc();
    mem_data_ok = 1'b0;
    #2 check_eq("wrrd_rdreq", 32'(mem_req), 32'd1);
    check_eq("wrrd_rdwr", 32'(mem_wr), 32'd0);
    check_eq("wrrd_rdaddr", mem_addr, 32'h200);
    check_eq("wrrd_rdacc", 32'(cpu_addr_ok), 32'd1);
    next_cyc();
    cpu_req     = 1'b0;
    mem_addr_ok = 1'b0;
    mem_rdata   = 32'h5A5A_5A5A;
    #2 check_eq("rdwait_mreq", 32'(mem_req), 32'd0);
    check_eq("rdwait_ok", 32'(cpu_data_ok), 32'd0);
    check_eq("rdwait_rdata0", cpu_rdata, 32'd0);
    next_cyc();
    next_cyc();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hCAFE_F00D;
    #2 check_eq("rd_ok", 32'(cpu_data_ok), 32'd1);
    check_eq("rd_data", cpu_rdata, 32'hCAFE_F00D);
    next_cyc();
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h5555_5555;
    #2 check_eq("idle_ok0", 32'(cpu_data_ok), 32'd0);
    check_eq("idle_rdata0", cpu_rdata, 32'd0);
    mem_rdata   = '0;

    // Word write buffered, read of the same word
    cpu_drive(1'b1, 1'b1, 2'b10, 32'h40, 32'hDEAD_BEEF);
    next_cyc();
    cpu_drive(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
`ifdef WB_READ_FORWARD_EN
    #2 check_eq("fwd_acc", 32'(cpu_addr_ok), 32'd1);
    check_eq("fwd_mwr", 32'(mem_wr), 32'd1);
    next_cyc();
    cpu_req = 1'b0;
    #2 check_eq("fwd_ok", 32'(cpu_data_ok), 32'd1);
    check_eq("fwd_data", cpu_rdata, 32'hDEAD_BEEF);
    check_eq("fwd_no_rdreq", 32'(mem_wr), 32'd1);
    next_cyc();
    mem_addr_ok = 1'b1;
    next_cyc();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    next_cyc();
    mem_data_ok = 1'b0;
`else
    drain_then_read("word", 32'h40, 32'hDEAD_BEEF);
`endif

    // Byte write buffered: same-word read is never forwarded
    cpu_drive(1'b1, 1'b1, 2'b00, 32'h41, 32'h0000_7700);
    next_cyc();
    cpu_drive(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
    drain_then_read("byte", 32'h40, 32'h1234_7700);

    // Outstanding-write limit of 7
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cpu_drive(1'b1, 1'b1, 2'b10, 32'h300 + 32'(4 * i), 32'hB0 + 32'(i));
      #2 check_eq("lim_acc", 32'(cpu_addr_ok), 32'd1);
      next_cyc();
    end
    cpu_req = 1'b0;
    #2 check_eq("lim_stall0", 32'(mem_req), 32'd0);
    next_cyc();
    #2 check_eq("lim_stall1", 32'(mem_req), 32'd0);
    mem_data_ok = 1'b1;
    #1 check_eq("lim_stall2", 32'(mem_req), 32'd0);
    next_cyc();
    mem_data_ok = 1'b0;
    #2 check_eq("lim_resume", 32'(mem_req), 32'd1);
    check_eq("lim_addr", mem_addr, 32'h31C);
    next_cyc();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    for (int i = 0; i < 7; i++) next_cyc();
    mem_data_ok = 1'b0;
    #2 check_eq("lim_empty", 32'(mem_req), 32'd0);

    // Reset discards buffered writes
    cpu_drive(1'b1, 1'b1, 2'b10, 32'h500, 32'hC0);
    next_cyc();
    cpu_drive(1'b1, 1'b1, 2'b10, 32'h504, 32'hC1);
    next_cyc();
    cpu_req = 1'b0;
    #2 check_eq("rstw_pre", 32'(mem_req), 32'd1);
    resetn = 1'b0;
    #1 check_eq("rstw_during", 32'(mem_req), 32'd0);
    next_cyc();
    resetn = 1'b1;
    #2 check_eq("rstw_after", 32'(mem_req), 32'd0);

    // Reset while a read is outstanding
    cpu_drive(1'b1, 1'b0, 2'b10, 32'h600, 32'h0);
    mem_addr_ok = 1'b1;
    #2 check_eq("rstr_acc", 32'(cpu_addr_ok), 32'd1);
    next_cyc();
    cpu_req     = 1'b0;
    mem_addr_ok = 1'b0;
    resetn      = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1111_1111;
    #2 check_eq("rstr_mreq", 32'(mem_req), 32'd0);
    check_eq("rstr_ok", 32'(cpu_data_ok), 32'd0);
    check_eq("rstr_rdata", cpu_rdata, 32'd0);
    next_cyc();
    mem_data_ok = 1'b0;
    resetn      = 1'b1;
    cpu_drive(1'b1, 1'b0, 2'b10, 32'h700, 32'h0);
    mem_addr_ok = 1'b1;
    #2 check_eq("rstr_reacc", 32'(cpu_addr_ok), 32'd1);
    check_eq("rstr_readdr", mem_addr, 32'h700);
    next_cyc();
    cpu_req     = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h2222_2222;
    #2 check_eq("rstr_reok", 32'(cpu_data_ok), 32'd1);
    check_eq("rstr_redata", cpu_rdata, 32'h2222_2222);
    next_cyc();
    mem_data_ok = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
